// File: rtl/bram_access_arbiter.sv
// ---------------------------------------------------------------------------
// bram_access_arbiter: round-robin sharing of the user BRAM between the
// Wishbone slave port and a valid/ack user port, with programmable wait states.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bram_access_arbiter #(
  parameter int          DELAYS  = 10,
  parameter logic [11:0] WB_BASE = 12'h380
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        u_req_i,
  input  logic        u_we_i,
  input  logic [3:0]  u_sel_i,
  input  logic [31:0] u_adr_i,
  input  logic [31:0] u_wdat_i,
  output logic        u_ack_o,
  output logic [31:0] u_rdat_o,
  output logic        bram_en_o,
  output logic [3:0]  bram_we_o,
  output logic [31:0] bram_a_o,
  output logic [31:0] bram_di_o,
  input  logic [31:0] bram_do_i,
  output logic        busy_o,
  output logic        grant_o
);

  localparam logic [15:0] LAST_CNT = 16'(DELAYS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t      state_q, state_d;
  logic [15:0] ctr_q, ctr_d;
  logic        rr_q, rr_d;       // 1 = user was granted last
  logic        grant_q, grant_d;
  logic        en_q, en_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] di_q, di_d;
  logic [31:0] rdat_q, rdat_d;
  logic        wack_q, wack_d;
  logic        uack_q, uack_d;
  logic        busy_q;

  logic wb_req;
  logic win;

  assign wb_req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20] == WB_BASE);
  // On a tie the requester that was not served last wins.
  assign win    = (wb_req & u_req_i) ? ~rr_q : u_req_i;

  // Outputs are computed from the next state so every port is a flop.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    en_d    = 1'b0;
    we_d    = 4'h0;
    adr_d   = adr_q;
    di_d    = di_q;
    rdat_d  = rdat_q;
    wack_d  = 1'b0;
    uack_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_req || u_req_i) begin
          grant_d = win;
          rr_d    = win;
          en_d    = 1'b1;
          we_d    = win ? (u_sel_i & {4{u_we_i}}) : (wbs_sel_i & {4{wbs_we_i}});
          adr_d   = win ? u_adr_i : wbs_adr_i;
          di_d    = win ? u_wdat_i : wbs_dat_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ctr_d   = 16'h0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ctr_q == LAST_CNT) begin
          rdat_d  = bram_do_i;
          wack_d  = ~grant_q;
          uack_d  = grant_q;
          state_d = S_ACK;
        end else begin
          ctr_d = ctr_q + 16'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      ctr_q   <= 16'h0;
      rr_q    <= 1'b1;
      grant_q <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 4'h0;
      adr_q   <= 32'h0;
      di_q    <= 32'h0;
      rdat_q  <= 32'h0;
      wack_q  <= 1'b0;
      uack_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      en_q    <= en_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      di_q    <= di_d;
      rdat_q  <= rdat_d;
      wack_q  <= wack_d;
      uack_q  <= uack_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign wbs_ack_o = wack_q;
  assign u_ack_o   = uack_q;
  assign wbs_dat_o = rdat_q;
  assign u_rdat_o  = rdat_q;
  assign bram_en_o = en_q;
  assign bram_we_o = we_q;
  assign bram_a_o  = adr_q;
  assign bram_di_o = di_q;
  assign busy_o    = busy_q;
  assign grant_o   = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_access_arbiter: directed self-checking bench for bram_access_arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bram_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cyc, stb, wwe;
  logic [3:0]  wsel;
  logic [31:0] wadr, wdat;
  logic        wack;
  logic [31:0] wrdat;
  logic        ureq, uwe;
  logic [3:0]  usel;
  logic [31:0] uadr, uwdat;
  logic        uack;
  logic [31:0] urdat;
  logic        ben;
  logic [3:0]  bwe;
  logic [31:0] ba, bdi;
  logic [31:0] bdo;
  logic        busy, grant;

  int total = 0;
  int bad   = 0;

  bram_access_arbiter #(.DELAYS(10), .WB_BASE(12'h380)) dut (
    .wb_clk_i (clk),   .wb_rst_i (rst_n),
    .wbs_cyc_i(cyc),   .wbs_stb_i(stb),   .wbs_we_i (wwe),
    .wbs_sel_i(wsel),  .wbs_adr_i(wadr),  .wbs_dat_i(wdat),
    .wbs_ack_o(wack),  .wbs_dat_o(wrdat),
    .u_req_i  (ureq),  .u_we_i   (uwe),   .u_sel_i  (usel),
    .u_adr_i  (uadr),  .u_wdat_i (uwdat),
    .u_ack_o  (uack),  .u_rdat_o (urdat),
    .bram_en_o(ben),   .bram_we_o(bwe),   .bram_a_o (ba),
    .bram_di_o(bdi),   .bram_do_i(bdo),
    .busy_o   (busy),  .grant_o  (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first synchronous BRAM model with byte enables.
  logic [31:0] mem [0:15];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      bdo <= 32'h0;
    end else if (ben) begin
      bdo <= mem[ba[5:2]];
      for (int b = 0; b < 4; b++)
        if (bwe[b]) mem[ba[5:2]][b*8 +: 8] <= bdi[b*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Runs until an ack appears (bounded), recording issue-cycle values.
  task automatic do_access(output int lat, output int en_cnt, output logic [3:0] we_s,
                           output logic [31:0] a_s, output logic [31:0] di_s,
                           output logic who, output logic [31:0] rd);
    bit done;
    done = 0; lat = -1; en_cnt = 0; we_s = 4'hx; a_s = 32'hx; di_s = 32'hx;
    who = 1'bx; rd = 32'hx;
    for (int k = 1; k <= 40 && !done; k++) begin
      tick();
      if (ben) begin
        en_cnt++; we_s = bwe; a_s = ba; di_s = bdi;
      end
      if (wack || uack) begin
        who = uack; rd = uack ? urdat : wrdat; lat = k; done = 1;
        if (wack && uack) who = 1'bx;
        cyc = 0; stb = 0; ureq = 0;
      end
    end
  endtask

  int          lat, enc;
  logic [3:0]  we_s;
  logic [31:0] a_s, di_s, rd;
  logic        who;
  int          ne, na;
  int          en_cyc [8];
  int          ack_cyc [8];
  logic        gr_at [8];
  logic        ua_at [8];
  logic [31:0] rd_at [8];
  bit          seen_ack, seen_en, seen_busy;

  initial begin
    rst_n = 0; cyc = 0; stb = 0; wwe = 0; wsel = 0; wadr = 0; wdat = 0;
    ureq = 0; uwe = 0; usel = 0; uadr = 0; uwdat = 0;
    repeat (3) tick();
    check("rst_outs", {28'h0, wack, uack, ben, busy}, 32'h0);
    check("rst_grant", {31'h0, grant}, 32'h0);
    rst_n = 1;
    tick();

    // Wishbone write
    cyc = 1; stb = 1; wwe = 1; wsel = 4'hF; wadr = 32'h3800_0004; wdat = 32'hDEAD_BEEF;
    do_access(lat, enc, we_s, a_s, di_s, who, rd);
    check("t1_latency", lat, 12);
    check("t1_en_count", enc, 1);
    check("t1_we", {28'h0, we_s}, 32'hF);
    check("t1_adr", a_s, 32'h3800_0004);
    check("t1_di", di_s, 32'hDEAD_BEEF);
    check("t1_who", {31'h0, who}, 32'h0);
    tick();
    check("t1_ack_pulse", {30'h0, wack, uack}, 32'h0);

    // Wishbone read
    cyc = 1; stb = 1; wwe = 0; wsel = 4'hF; wadr = 32'h3800_0004; wdat = 32'h0;
    do_access(lat, enc, we_s, a_s, di_s, who, rd);
    check("t2_latency", lat, 12);
    check("t2_we", {28'h0, we_s}, 32'h0);
    check("t2_rdata", rd, 32'hDEAD_BEEF);
    check("t2_who", {31'h0, who}, 32'h0);
    tick();

    // Continuous tie: WB writes, user reads back
    rst_n = 0; tick(); rst_n = 1; tick();
    cyc = 1; stb = 1; wwe = 1; wsel = 4'hF; wadr = 32'h3800_0004; wdat = 32'hDEAD_BEEF;
    ureq = 1; uwe = 0; usel = 4'hF; uadr = 32'h0000_0004; uwdat = 32'h0;
    ne = 0; na = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (ben && ne < 8) begin en_cyc[ne] = k; gr_at[ne] = grant; ne++; end
      if ((wack || uack) && na < 8) begin
        ack_cyc[na] = k; ua_at[na] = uack; rd_at[na] = uack ? urdat : wrdat; na++;
      end
    end
    cyc = 0; stb = 0; ureq = 0;
    check("t3_issues", ne, 5);
    check("t3_acks", na, 4);
    if (ne >= 4 && na >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t3_grant%0d", i), {31'h0, gr_at[i]}, {31'h0, i[0]});
        check($sformatf("t3_ackport%0d", i), {31'h0, ua_at[i]}, {31'h0, i[0]});
      end
      for (int i = 0; i < 3; i++)
        check($sformatf("t3_gap%0d", i), en_cyc[i+1] - ack_cyc[i], 2);
      check("t3_user_rd", rd_at[1], 32'hDEAD_BEEF);
    end
    repeat (20) tick();
    check("t3_idle", {31'h0, busy}, 32'h0);

    // Non-decoded Wishbone cycle
    cyc = 1; stb = 1; wwe = 1; wsel = 4'hF; wadr = 32'h3000_0000; wdat = 32'h1234_5678;
    seen_ack = 0; seen_en = 0; seen_busy = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (wack || uack) seen_ack = 1;
      if (ben) seen_en = 1;
      if (busy) seen_busy = 1;
    end
    cyc = 0; stb = 0;
    check("t4_no_ack", {31'h0, seen_ack}, 32'h0);
    check("t4_no_en", {31'h0, seen_en}, 32'h0);
    check("t4_no_busy", {31'h0, seen_busy}, 32'h0);
    tick();

    // Reset in the middle of a user read
    ureq = 1; uwe = 0; usel = 4'hF; uadr = 32'h0000_0004;
    seen_ack = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (wack || uack) seen_ack = 1;
    end
    check("t5_busy_before", {31'h0, busy}, 32'h1);
    rst_n = 0;
    tick();
    if (wack || uack) seen_ack = 1;
    check("t5_no_ack", {31'h0, seen_ack}, 32'h0);
    check("t5_ctrl_zero", {26'h0, ben, bwe, busy}, 32'h0);
    check("t5_grant_zero", {31'h0, grant}, 32'h0);
    check("t5_adr_zero", ba, 32'h0);
    check("t5_di_zero", bdi, 32'h0);
    check("t5_rdat_zero", urdat | wrdat, 32'h0);
    rst_n = 1;
    do_access(lat, enc, we_s, a_s, di_s, who, rd);
    check("t5_latency", lat, 12);
    check("t5_who", {31'h0, who}, 32'h1);
    check("t5_en_count", enc, 1);
    tick();

    // User byte write then user read
    ureq = 1; uwe = 1; usel = 4'b0010; uadr = 32'h0000_0008; uwdat = 32'h1122_AB44;
    do_access(lat, enc, we_s, a_s, di_s, who, rd);
    check("t6_we_byte", {28'h0, we_s}, 32'h2);
    check("t6_who", {31'h0, who}, 32'h1);
    tick();
    ureq = 1; uwe = 0; usel = 4'hF; uadr = 32'h0000_0008; uwdat = 32'h0;
    do_access(lat, enc, we_s, a_s, di_s, who, rd);
    check("t6_we_read", {28'h0, we_s}, 32'h0);
    check("t6_rdata", rd, 32'h0000_AB00);
    check("t6_latency", lat, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
